// File: rtl/udp_gen_pkg.sv
// Shared types, header constants and the IPv4 header checksum for udp_frame_gen.
package udp_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CSUM,
        STREAM,
        GAP
    } fsm_state_t;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL    = 8'h45;
    localparam logic [15:0] IP_FLAGS_DF   = 16'h4000;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;

    localparam int unsigned HDR_BYTES     = 42;
    localparam int unsigned IP_HDR_BYTES  = 20;
    localparam int unsigned UDP_HDR_BYTES = 8;

    // Configuration captured at the start of every frame.
    typedef struct packed {
        logic [47:0] dst_mac;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [10:0] len;
        logic [15:0] frame_cnt;
    } cfg_t;

    // One's-complement sum of ten 16-bit words; the checksum field must be zero on entry.
    function automatic logic [15:0] ip_csum(input logic [159:0] hdr);
        logic [19:0] sum;
        sum = '0;
        for (int i = 0; i < 10; i++) begin
            sum = sum + {4'h0, hdr[i*16 +: 16]};
        end
        sum = {4'h0, sum[15:0]} + {16'h0000, sum[19:16]};
        sum = {4'h0, sum[15:0]} + {16'h0000, sum[19:16]};
        return ~sum[15:0];
    endfunction

endpackage

// File: rtl/udp_hdr_builder.sv
// Combinational Ethernet/IPv4/UDP header assembly; byte 0 of the frame lands on hdr_o[7:0].
module udp_hdr_builder
    import udp_gen_pkg::*;
#(
    parameter logic [47:0] SRC_MAC = 48'h1A1B1C1D1E1F,
    parameter logic [7:0]  IP_TTL  = 8'd64
) (
    input  logic [47:0]            dst_mac_i,
    input  logic [31:0]            src_ip_i,
    input  logic [31:0]            dst_ip_i,
    input  logic [15:0]            src_port_i,
    input  logic [15:0]            dst_port_i,
    input  logic [10:0]            len_i,
    input  logic [15:0]            seq_i,
    input  logic [15:0]            csum_i,
    output logic [HDR_BYTES*8-1:0] hdr_o,
    output logic [159:0]           ip_hdr_o
);

    logic [15:0]            ip_len;
    logic [15:0]            udp_len;
    logic [HDR_BYTES*8-1:0] hdr_be;

    // Field assembly in wire order (first transmitted byte in the MS position).
    always_comb begin
        ip_len   = 16'(len_i) + 16'(IP_HDR_BYTES + UDP_HDR_BYTES);
        udp_len  = 16'(len_i) + 16'(UDP_HDR_BYTES);
        ip_hdr_o = {IP_VER_IHL, 8'h00, ip_len, seq_i, IP_FLAGS_DF, IP_TTL, IP_PROTO_UDP,
                    16'h0000, src_ip_i, dst_ip_i};
        hdr_be   = {dst_mac_i, SRC_MAC, ETH_TYPE_IPV4,
                    IP_VER_IHL, 8'h00, ip_len, seq_i, IP_FLAGS_DF, IP_TTL, IP_PROTO_UDP,
                    csum_i, src_ip_i, dst_ip_i,
                    src_port_i, dst_port_i, udp_len, 16'h0000};
    end

    // Byte-reverse so that the lane mux can index by frame byte offset.
    always_comb begin
        hdr_o = '0;
        for (int b = 0; b < HDR_BYTES; b++) begin
            hdr_o[b*8 +: 8] = hdr_be[(HDR_BYTES-1-b)*8 +: 8];
        end
    end

endmodule

// File: rtl/udp_frame_gen.sv
// UDP/IPv4/Ethernet frame source on an AXI4-Stream master with count and gap control.
module udp_frame_gen
    import udp_gen_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter logic [47:0] SRC_MAC     = 48'h1A1B1C1D1E1F,
    parameter logic [7:0]  IP_TTL      = 8'd64,
    parameter int unsigned GAP_CYCLES  = 12,
    parameter int unsigned MIN_PAYLOAD = 18,
    parameter int unsigned MAX_PAYLOAD = 1472
) (
    input  logic                    clk_i,
    input  logic                    a_rst_n_i,
    input  logic                    en_i,
    input  logic [15:0]             frame_cnt_i,
    input  logic [10:0]             payload_len_i,
    input  logic [47:0]             dst_mac_addr_i,
    input  logic [31:0]             src_ipv4_addr_i,
    input  logic [31:0]             dst_ipv4_addr_i,
    input  logic [15:0]             src_udp_port_i,
    input  logic [15:0]             dst_udp_port_i,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata_o,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep_o,
    output logic                    m_axis_tvalid_o,
    output logic                    m_axis_tlast_o,
    input  logic                    m_axis_tready_i,
    output logic                    busy_o,
    output logic [31:0]             frames_sent_o
);

    localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

    fsm_state_t state_q, state_d;
    cfg_t       cfg_q, cfg_d, cfg_in;
    logic [11:0] off_q, off_d;
    logic [15:0] seq_q, seq_d;
    logic [31:0] sent_q, sent_d;
    logic [15:0] done_q, done_d;
    logic [15:0] gap_q, gap_d;
    logic [15:0] csum_q, csum_d;
    logic        hold_q, hold_d;

    logic [HDR_BYTES*8-1:0] hdr;
    logic [159:0]           ip_hdr;
    logic [11:0]            tot_len;
    logic                   fire;

    udp_hdr_builder #(
        .SRC_MAC (SRC_MAC),
        .IP_TTL  (IP_TTL)
    ) u_hdr (
        .dst_mac_i  (cfg_q.dst_mac),
        .src_ip_i   (cfg_q.src_ip),
        .dst_ip_i   (cfg_q.dst_ip),
        .src_port_i (cfg_q.src_port),
        .dst_port_i (cfg_q.dst_port),
        .len_i      (cfg_q.len),
        .seq_i      (seq_q),
        .csum_i     (csum_q),
        .hdr_o      (hdr),
        .ip_hdr_o   (ip_hdr)
    );

    // Snapshot of the configuration inputs with the payload length clamped.
    always_comb begin
        cfg_in.dst_mac   = dst_mac_addr_i;
        cfg_in.src_ip    = src_ipv4_addr_i;
        cfg_in.dst_ip    = dst_ipv4_addr_i;
        cfg_in.src_port  = src_udp_port_i;
        cfg_in.dst_port  = dst_udp_port_i;
        cfg_in.frame_cnt = frame_cnt_i;
        if (payload_len_i < 11'(MIN_PAYLOAD)) begin
            cfg_in.len = 11'(MIN_PAYLOAD);
        end else if (payload_len_i > 11'(MAX_PAYLOAD)) begin
            cfg_in.len = 11'(MAX_PAYLOAD);
        end else begin
            cfg_in.len = payload_len_i;
        end
    end

    assign tot_len         = 12'(cfg_q.len) + 12'(HDR_BYTES);
    assign m_axis_tvalid_o = (state_q == STREAM);
    assign m_axis_tlast_o  = m_axis_tvalid_o && (off_q + 12'(KEEP_WIDTH) >= tot_len);
    assign busy_o          = (state_q != IDLE);
    assign frames_sent_o   = sent_q;
    assign fire            = m_axis_tvalid_o && m_axis_tready_i;

    // Next-state logic; hold_q blocks a restart after a counted run until en_i drops.
    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        off_d   = off_q;
        seq_d   = seq_q;
        sent_d  = sent_q;
        done_d  = done_q;
        gap_d   = gap_q;
        csum_d  = csum_q;
        hold_d  = hold_q && en_i;
        unique case (state_q)
            IDLE: begin
                if (en_i && !hold_q) begin
                    cfg_d   = cfg_in;
                    off_d   = '0;
                    state_d = CSUM;
                end
            end
            CSUM: begin
                csum_d  = ip_csum(ip_hdr);
                state_d = STREAM;
            end
            STREAM: begin
                if (fire) begin
                    if (m_axis_tlast_o) begin
                        sent_d  = sent_q + 32'd1;
                        seq_d   = seq_q + 16'd1;
                        done_d  = done_q + 16'd1;
                        gap_d   = '0;
                        state_d = GAP;
                    end else begin
                        off_d = off_q + 12'(KEEP_WIDTH);
                    end
                end
            end
            GAP: begin
                // GAP_CYCLES idle cycles plus one decision cycle.
                if (gap_q == 16'(GAP_CYCLES)) begin
                    if (!en_i || (cfg_q.frame_cnt != 16'd0 && done_q == cfg_q.frame_cnt)) begin
                        done_d  = '0;
                        hold_d  = en_i;
                        state_d = IDLE;
                    end else begin
                        cfg_d   = cfg_in;
                        off_d   = '0;
                        state_d = CSUM;
                    end
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            state_q <= IDLE;
            cfg_q   <= '0;
            off_q   <= '0;
            seq_q   <= '0;
            sent_q  <= '0;
            done_q  <= '0;
            gap_q   <= '0;
            csum_q  <= '0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            off_q   <= off_d;
            seq_q   <= seq_d;
            sent_q  <= sent_d;
            done_q  <= done_d;
            gap_q   <= gap_d;
            csum_q  <= csum_d;
            hold_q  <= hold_d;
        end
    end

    // Per-lane byte mux: header bytes, then the incrementing payload pattern, zero past the end.
    always_comb begin : lane_mux
        logic [11:0]            lane_idx;
        logic [HDR_BYTES*8-1:0] hdr_sh;
        logic [7:0]             pay;
        m_axis_tdata_o = '0;
        m_axis_tkeep_o = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            lane_idx = off_q + 12'(i);
            hdr_sh   = hdr >> {lane_idx[5:0], 3'b000};
            pay      = lane_idx[7:0] - 8'(HDR_BYTES) + seq_q[7:0];
            if (m_axis_tvalid_o && lane_idx < tot_len) begin
                m_axis_tkeep_o[i]       = 1'b1;
                m_axis_tdata_o[i*8 +: 8] = (lane_idx < 12'(HDR_BYTES)) ? hdr_sh[7:0] : pay;
            end
        end
    end

endmodule

// File: tb/tb_udp_frame_gen.sv
// Scoreboard bench for udp_frame_gen (64-bit data path).
module tb_udp_frame_gen;

    localparam int GAP = 12;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] frame_cnt;
    logic [10:0] payload_len;
    logic [47:0] dst_mac;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] sport;
    logic [15:0] dport;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic        tready;
    logic        busy;
    logic [31:0] frames_sent;

    int checks = 0;
    int failures = 0;

    beat_t       exp_q[$];
    logic [7:0]  cur_bytes[$];
    logic [7:0]  rx_bytes[$];
    int          cur_beats = 0;
    int          rx_beats = 0;
    logic [7:0]  rx_keep = '0;
    int          rx_frames = 0;
    logic [15:0] seq_m = '0;
    logic [31:0] sent_m = '0;
    logic        rand_mode = 1'b0;

    always #5 clk_i = ~clk_i;

    udp_frame_gen dut (
        .clk_i           (clk_i),
        .a_rst_n_i       (rst_n),
        .en_i            (en),
        .frame_cnt_i     (frame_cnt),
        .payload_len_i   (payload_len),
        .dst_mac_addr_i  (dst_mac),
        .src_ipv4_addr_i (src_ip),
        .dst_ipv4_addr_i (dst_ip),
        .src_udp_port_i  (sport),
        .dst_udp_port_i  (dport),
        .m_axis_tdata_o  (tdata),
        .m_axis_tkeep_o  (tkeep),
        .m_axis_tvalid_o (tvalid),
        .m_axis_tlast_o  (tlast),
        .m_axis_tready_i (tready),
        .busy_o          (busy),
        .frames_sent_o   (frames_sent)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference frame from the field layout; pushes one expected entry per beat.
    task automatic push_frame(input int len);
        logic [7:0]  f[$];
        logic [47:0] smac;
        logic [31:0] s;
        logic [15:0] c;
        int          lc;
        int          t;
        beat_t       e;
        smac = 48'h1A1B1C1D1E1F;
        lc = (len < 18) ? 18 : (len > 1472) ? 1472 : len;
        for (int i = 5; i >= 0; i--) f.push_back(dst_mac[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) f.push_back(smac[i*8 +: 8]);
        f.push_back(8'h08); f.push_back(8'h00);
        f.push_back(8'h45); f.push_back(8'h00);
        f.push_back(8'((28 + lc) >> 8)); f.push_back(8'(28 + lc));
        f.push_back(seq_m[15:8]); f.push_back(seq_m[7:0]);
        f.push_back(8'h40); f.push_back(8'h00);
        f.push_back(8'd64); f.push_back(8'd17);
        f.push_back(8'h00); f.push_back(8'h00);
        for (int i = 3; i >= 0; i--) f.push_back(src_ip[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) f.push_back(dst_ip[i*8 +: 8]);
        f.push_back(sport[15:8]); f.push_back(sport[7:0]);
        f.push_back(dport[15:8]); f.push_back(dport[7:0]);
        f.push_back(8'((8 + lc) >> 8)); f.push_back(8'(8 + lc));
        f.push_back(8'h00); f.push_back(8'h00);
        s = 0;
        for (int i = 0; i < 10; i++) s = s + {16'h0, f[14 + 2*i], f[15 + 2*i]};
        while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        c = ~s[15:0];
        f[24] = c[15:8];
        f[25] = c[7:0];
        for (int k = 0; k < lc; k++) f.push_back(8'(k + int'(seq_m[7:0])));
        t = 42 + lc;
        for (int b = 0; b < t; b += 8) begin
            e = '0;
            for (int j = 0; j < 8; j++) begin
                if (b + j < t) begin
                    e.d[j*8 +: 8] = f[b + j];
                    e.k[j] = 1'b1;
                end
            end
            e.l = (b + 8 >= t);
            exp_q.push_back(e);
        end
        seq_m++;
        sent_m++;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (rx_frames < target && n < budget) begin
            @(posedge clk_i);
            n++;
        end
        chk("frames_received", 64'(rx_frames), 64'(target));
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk_i);
            n++;
        end
        chk("busy_low", 64'(busy), 64'(0));
    endtask

    // Counted run with en_i held high; checks the generator stops by itself.
    task automatic run_frames(input int len, input int cnt);
        int base = rx_frames;
        @(negedge clk_i);
        payload_len = 11'(len);
        frame_cnt   = 16'(cnt);
        for (int i = 0; i < cnt; i++) push_frame(len);
        en = 1'b1;
        wait_frames(base + cnt, 3000 * cnt);
        wait_idle(100);
        repeat (40) @(posedge clk_i);
        chk("run_frame_count", 64'(rx_frames), 64'(base + cnt));
        chk("busy_after_run", 64'(busy), 64'(0));
        chk("frames_sent", 64'(frames_sent), 64'(sent_m));
        @(negedge clk_i);
        en = 1'b0;
        repeat (2) @(posedge clk_i);
    endtask

    // Sink readiness: always ready, or a coin toss each cycle.
    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: scoreboard pops on every handshake, plus stall stability and inter-frame idle.
    initial begin
        logic        stall = 1'b0;
        logic        have_prev = 1'b0;
        int          idle_cnt = 0;
        logic [63:0] st_d;
        logic [7:0]  st_k;
        logic        st_l;
        beat_t       e;
        forever begin
            @(negedge clk_i);
            if (!rst_n) begin
                cur_bytes.delete();
                cur_beats = 0;
                stall = 1'b0;
                have_prev = 1'b0;
            end else begin
                if (stall) begin
                    chk("stall_valid", 64'(tvalid), 64'(1));
                    chk("stall_data", tdata, st_d);
                    chk("stall_keep", 64'(tkeep), 64'(st_k));
                    chk("stall_last", 64'(tlast), 64'(st_l));
                end
                stall = tvalid && !tready;
                st_d = tdata;
                st_k = tkeep;
                st_l = tlast;
                if (tvalid && cur_beats == 0 && have_prev) begin
                    chk("gap_idle_ok", 64'(idle_cnt >= GAP + 2), 64'(1));
                    have_prev = 1'b0;
                end
                if (!tvalid) idle_cnt++;
                if (tvalid && tready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", tdata, 64'(0));
                        failures++;
                        $display("FAIL unexpected_beat actual=beat required=none");
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", tdata, e.d);
                        chk("beat_keep", 64'(tkeep), 64'(e.k));
                        chk("beat_last", 64'(tlast), 64'(e.l));
                    end
                    for (int j = 0; j < 8; j++) if (tkeep[j]) cur_bytes.push_back(tdata[j*8 +: 8]);
                    cur_beats++;
                    if (tlast) begin
                        rx_bytes = cur_bytes;
                        rx_beats = cur_beats;
                        rx_keep = tkeep;
                        rx_frames++;
                        cur_bytes.delete();
                        cur_beats = 0;
                        have_prev = 1'b1;
                        idle_cnt = 0;
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        rst_n = 1'b0;
        en = 1'b0;
        frame_cnt = 16'd1;
        payload_len = 11'd87;
        dst_mac = 48'h02505A123456;
        src_ip = 32'hC0A80001;
        dst_ip = 32'hC0A800C7;
        sport = 16'h1234;
        dport = 16'h5678;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_tvalid", 64'(tvalid), 64'(0));
        chk("reset_tlast", 64'(tlast), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_tdata", tdata, 64'(0));
        chk("reset_tkeep", 64'(tkeep), 64'(0));
        chk("reset_frames_sent", 64'(frames_sent), 64'(0));
        @(negedge clk_i);
        rst_n = 1'b1;

        // Checksum frame, ID 0.
        run_frames(87, 1);
        chk("ip_total_len", {56'h0, rx_bytes[16], rx_bytes[17]} >> 8, 64'h0073 >> 8);
        chk("ip_total_len_lo", 64'(rx_bytes[17]), 64'h73);
        chk("ip_id", 64'({rx_bytes[18], rx_bytes[19]}), 64'h0000);
        chk("ip_csum", 64'({rx_bytes[24], rx_bytes[25]}), 64'hB861);
        chk("udp_len", 64'({rx_bytes[38], rx_bytes[39]}), 64'h005F);

        // Minimum frames.
        run_frames(18, 1);
        chk("min_beats", 64'(rx_beats), 64'(8));
        chk("min_last_keep", 64'(rx_keep), 64'h0F);
        run_frames(22, 1);
        chk("l22_beats", 64'(rx_beats), 64'(8));
        chk("l22_last_keep", 64'(rx_keep), 64'hFF);

        // Clamping.
        run_frames(5, 1);
        chk("clamp_lo_iplen", 64'({rx_bytes[16], rx_bytes[17]}), 64'h002E);
        chk("clamp_lo_beats", 64'(rx_beats), 64'(8));
        run_frames(2000, 1);
        chk("clamp_hi_beats", 64'(rx_beats), 64'(190));
        chk("clamp_hi_last_keep", 64'(rx_keep), 64'h03);
        chk("clamp_hi_bytes", 64'(rx_bytes.size()), 64'(1514));

        // Backpressure over three frames.
        rand_mode = 1'b1;
        run_frames(100, 3);
        rand_mode = 1'b0;

        // en_i dropped mid-frame in continuous mode: the frame still completes.
        base = rx_frames;
        @(negedge clk_i);
        payload_len = 11'd200;
        frame_cnt = 16'd0;
        push_frame(200);
        en = 1'b1;
        n = 0;
        while (cur_beats < 5 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        en = 1'b0;
        wait_frames(base + 1, 500);
        wait_idle(100);
        repeat (30) @(posedge clk_i);
        chk("abort_en_frames", 64'(rx_frames), 64'(base + 1));
        chk("abort_en_queue", 64'(exp_q.size()), 64'(0));

        // Asynchronous reset mid-frame.
        @(negedge clk_i);
        payload_len = 11'd300;
        push_frame(300);
        en = 1'b1;
        n = 0;
        while (cur_beats < 10 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        @(posedge clk_i);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tvalid", 64'(tvalid), 64'(0));
        chk("rst_mid_tlast", 64'(tlast), 64'(0));
        chk("rst_mid_frames_sent", 64'(frames_sent), 64'(0));
        exp_q.delete();
        en = 1'b0;
        seq_m = '0;
        sent_m = '0;
        repeat (2) @(negedge clk_i);
        rst_n = 1'b1;
        repeat (2) @(posedge clk_i);
        chk("post_rst_busy", 64'(busy), 64'(0));

        // Counted run after reset: IDs 0,1,2.
        base = rx_frames;
        run_frames(30, 3);
        chk("count_last_id", 64'({rx_bytes[18], rx_bytes[19]}), 64'h0002);
        chk("count_frames_sent", 64'(frames_sent), 64'(3));

        chk("final_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
